// File: rtl/fir_axil_pkg.sv
// rtl/fir_axil_pkg.sv - shared FSM state type and FIR config register map for axil_cfg_master
package fir_axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_A,
    RD_D,
    RESP
  } axil_state_t;

  // FIR configuration register map
  localparam logic [11:0] AP_CTRL    = 12'h000;
  localparam logic [11:0] DATA_LEN   = 12'h010;
  localparam logic [11:0] TAP_BASE   = 12'h040;
  localparam int          TAP_STRIDE = 4;

  // ap_ctrl bit positions
  localparam int AP_START_BIT = 0;
  localparam int AP_DONE_BIT  = 1;
  localparam int AP_IDLE_BIT  = 2;

  // Address of coefficient tap number idx
  function automatic logic [11:0] tap_addr(input int idx);
    return TAP_BASE + 12'(idx * TAP_STRIDE);
  endfunction

endpackage

// File: rtl/axil_chan_hold.sv
// rtl/axil_chan_hold.sv - valid-hold / done-flag cell for one AXI-Lite address or data channel
module axil_chan_hold #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  input  logic             abort,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             done
);

  logic done_q;

  // Raise valid with a fresh payload on load; drop it on its own handshake or on abort.
  // The payload register is only rewritten on load, so it stays stable while valid is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= 1'b0;
      done_q <= 1'b0;
      data   <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      done_q <= 1'b0;
      data   <= load_data;
    end else if (abort) begin
      valid  <= 1'b0;
    end else if (valid && ready) begin
      valid  <= 1'b0;
      done_q <= 1'b1;
    end
  end

  // Done includes the handshake happening this cycle so the FSM can leave without an extra cycle
  assign done = done_q | (valid & ready);

endmodule

// File: rtl/axil_cfg_master.sv
// rtl/axil_cfg_master.sv - AXI4-Lite config initiator for the FIR; optional watchdog via AXIL_CFG_MASTER_TIMEOUT_EN
module axil_cfg_master #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pTIMEOUT    = 16
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_we,
  input  logic [pADDR_WIDTH-1:0] cmd_addr,
  input  logic [pDATA_WIDTH-1:0] cmd_wdata,
  output logic                   rsp_valid,
  output logic [pDATA_WIDTH-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [pDATA_WIDTH-1:0] wdata,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [pADDR_WIDTH-1:0] araddr,
  output logic                   arvalid,
  input  logic                   arready,
  input  logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   rvalid,
  output logic                   rready
);

  import fir_axil_pkg::*;

  axil_state_t state, next_state;

  logic accept;
  logic aw_done, w_done, ar_done;
  logic timeout_hit;
  logic to_fire;
  logic [pDATA_WIDTH-1:0] rdata_q;

  assign accept = cmd_valid & cmd_ready;

  axil_chan_hold #(.WIDTH(pADDR_WIDTH)) u_aw (
    .clk       (axis_clk),
    .rst       (axis_rst),
    .load      (accept & cmd_we),
    .load_data (cmd_addr),
    .ready     (awready),
    .abort     (to_fire),
    .valid     (awvalid),
    .data      (awaddr),
    .done      (aw_done)
  );

  axil_chan_hold #(.WIDTH(pDATA_WIDTH)) u_w (
    .clk       (axis_clk),
    .rst       (axis_rst),
    .load      (accept & cmd_we),
    .load_data (cmd_wdata),
    .ready     (wready),
    .abort     (to_fire),
    .valid     (wvalid),
    .data      (wdata),
    .done      (w_done)
  );

  axil_chan_hold #(.WIDTH(pADDR_WIDTH)) u_ar (
    .clk       (axis_clk),
    .rst       (axis_rst),
    .load      (accept & ~cmd_we),
    .load_data (cmd_addr),
    .ready     (arready),
    .abort     (to_fire),
    .valid     (arvalid),
    .data      (araddr),
    .done      (ar_done)
  );

  // State register
  always_ff @(posedge axis_clk) begin
    if (axis_rst) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state and handshake outputs; completion always wins over a coincident timeout
  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    rready     = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    to_fire    = 1'b0;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) next_state = cmd_we ? WR : RD_A;
      end
      WR: begin
        if (aw_done && w_done) begin
          next_state = RESP;
        end else if (timeout_hit) begin
          next_state = RESP;
          to_fire    = 1'b1;
        end
      end
      RD_A: begin
        if (ar_done) begin
          next_state = RD_D;
        end else if (timeout_hit) begin
          next_state = RESP;
          to_fire    = 1'b1;
        end
      end
      RD_D: begin
        rready = 1'b1;
        if (rvalid) begin
          next_state = RESP;
        end else if (timeout_hit) begin
          next_state = RESP;
          to_fire    = 1'b1;
        end
      end
      RESP: begin
        rsp_valid  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Read-data capture; cleared on accept so writes and timeouts report zero
  always_ff @(posedge axis_clk) begin
    if (axis_rst)                        rdata_q <= '0;
    else if (accept)                     rdata_q <= '0;
    else if (state == RD_D && rvalid)    rdata_q <= rdata;
  end

  assign rsp_rdata = rdata_q;

`ifdef AXIL_CFG_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(pTIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(pTIMEOUT - 1);

  logic [CNT_W-1:0] cnt;
  logic             err_q;
  logic             active;

  assign active      = (state == WR) || (state == RD_A) || (state == RD_D);
  assign timeout_hit = active && (cnt >= LIMIT);

  // Per-transaction watchdog: counts in-flight cycles and saturates at the limit
  always_ff @(posedge axis_clk) begin
    if (axis_rst)                     cnt <= '0;
    else if (accept)                  cnt <= '0;
    else if (active && (cnt < LIMIT)) cnt <= cnt + 1'b1;
  end

  // Error flag for the response of the current transaction
  always_ff @(posedge axis_clk) begin
    if (axis_rst)     err_q <= 1'b0;
    else if (accept)  err_q <= 1'b0;
    else if (to_fire) err_q <= 1'b1;
  end

  assign rsp_err = err_q & rsp_valid;
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign rsp_err        = 1'b0;
  assign unused_timeout = |32'(pTIMEOUT);
`endif

endmodule

// File: tb/tb_axil_cfg_master.sv
// tb/tb_axil_cfg_master.sv - self-checking bench for axil_cfg_master with response scoreboard
module tb_axil_cfg_master;

  import fir_axil_pkg::*;

  logic        axis_clk = 1'b0;
  logic        axis_rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic [11:0] awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, arvalid, arready;
  logic [31:0] wdata, rdata;
  logic        rvalid, rready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          t;
  } exp_t;

  exp_t exp_q[$];

  axil_cfg_master #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .pTIMEOUT(16)) dut (
    .axis_clk  (axis_clk),
    .axis_rst  (axis_rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .awaddr    (awaddr),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wvalid    (wvalid),
    .wready    (wready),
    .araddr    (araddr),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .rready    (rready)
  );

  always #5 axis_clk = ~axis_clk;

  always @(posedge axis_clk) cyc <= cyc + 1;

  // Present one command, wait (bounded) until it is accepted, and push its expected response.
  // Returns one ns after the accept edge with cmd_valid dropped.
  task automatic send(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                      input logic [31:0] erd, input logic eerr, input int lat, output bit ok);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wd;
    @(negedge axis_clk);
    while (!cmd_ready && n < 50) begin
      @(negedge axis_clk);
      n++;
    end
    ok = (cmd_ready === 1'b1);
    if (ok) exp_q.push_back('{rdata: erd, err: eerr, lat: lat, t: cyc + 1});
    @(posedge axis_clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic idle_slave();
    awready = 1'b0;
    wready  = 1'b0;
    arready = 1'b0;
    rvalid  = 1'b0;
    rdata   = 32'h0;
    repeat (2) @(posedge axis_clk);
    #1;
  endtask

  task automatic test_reset();
    axis_rst  = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0;
    repeat (3) @(posedge axis_clk);
    @(negedge axis_clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if ({awvalid, wvalid, arvalid, rready} !== 4'b0) begin errors++; $display("FAIL reset_valids: got %b want 0000", {awvalid, wvalid, arvalid, rready}); end
    checks++; if ({rsp_valid, rsp_err} !== 2'b0) begin errors++; $display("FAIL reset_rsp: got %b want 00", {rsp_valid, rsp_err}); end
    checks++; if ({awaddr, wdata, araddr, rsp_rdata} !== 88'h0) begin errors++; $display("FAIL reset_addr_data: got %h want 0", {awaddr, wdata, araddr, rsp_rdata}); end
    axis_rst = 1'b0;
    @(posedge axis_clk);
    #1;
  endtask

  task automatic test_write_fast();
    bit ok; int rel, nrsp; exp_t e;
    nrsp = 0;
    awready = 1'b1; wready = 1'b1;
    send(1'b1, tap_addr(0), 32'h0000_000A, 32'h0, 1'b0, 2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_fast_accept: cmd_ready %b want 1", cmd_ready); end
    for (int k = 0; k < 5; k++) begin
      @(negedge axis_clk);
      rel = cyc - exp_q[$].t + 1;
      if (rel == 1) begin
        checks++; if ({awvalid, wvalid} !== 2'b11) begin errors++; $display("FAIL wr_fast_valids_t1: got %b want 11", {awvalid, wvalid}); end
        checks++; if (awaddr !== 12'h040 || wdata !== 32'h0000_000A) begin errors++; $display("FAIL wr_fast_payload: got %h/%h want 040/0000000a", awaddr, wdata); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_fast_busy: got %b want 1", busy); end
      end
      if (rel == 2) begin
        checks++; if ({awvalid, wvalid} !== 2'b00) begin errors++; $display("FAIL wr_fast_valids_t2: got %b want 00", {awvalid, wvalid}); end
      end
      if (rsp_valid) begin
        nrsp++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL wr_fast_unexpected_rsp: queue empty"); end
        else begin
          e = exp_q.pop_front();
          checks++; if (rsp_rdata !== e.rdata) begin errors++; $display("FAIL wr_fast_rdata: got %h want %h", rsp_rdata, e.rdata); end
          checks++; if (rsp_err !== e.err) begin errors++; $display("FAIL wr_fast_err: got %b want %b", rsp_err, e.err); end
          checks++; if (cyc + 1 - e.t != e.lat) begin errors++; $display("FAIL wr_fast_latency: got %0d want %0d", cyc + 1 - e.t, e.lat); end
        end
      end
    end
    checks++; if (nrsp != 1) begin errors++; $display("FAIL wr_fast_rsp_count: got %0d want 1", nrsp); end
    exp_q.delete();
    idle_slave();
  endtask

  task automatic test_write_aw_delayed();
    bit ok; int rel, nrsp, t0; exp_t e;
    nrsp = 0;
    awready = 1'b0; wready = 1'b0;
    send(1'b1, DATA_LEN, 32'h0000_0258, 32'h0, 1'b0, 5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_dly_accept: cmd_ready %b want 1", cmd_ready); end
    t0 = cyc;
    for (int k = 0; k < 8; k++) begin
      @(negedge axis_clk);
      rel = cyc - t0 + 1;
      if (rel == 1) begin
        checks++; if ({awvalid, wvalid} !== 2'b11) begin errors++; $display("FAIL wr_dly_valids_t1: got %b want 11", {awvalid, wvalid}); end
      end
      if (rel >= 2 && rel <= 4) begin
        checks++; if ({awvalid, wvalid} !== 2'b10) begin errors++; $display("FAIL wr_dly_hold_t%0d: got %b want 10", rel, {awvalid, wvalid}); end
        checks++; if (awaddr !== 12'h010) begin errors++; $display("FAIL wr_dly_awaddr_t%0d: got %h want 010", rel, awaddr); end
      end
      if (rel == 5) begin
        checks++; if (awvalid !== 1'b0) begin errors++; $display("FAIL wr_dly_aw_drop: got %b want 0", awvalid); end
      end
      if (rsp_valid) begin
        nrsp++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL wr_dly_unexpected_rsp: queue empty"); end
        else begin
          e = exp_q.pop_front();
          checks++; if (rsp_rdata !== e.rdata) begin errors++; $display("FAIL wr_dly_rdata: got %h want %h", rsp_rdata, e.rdata); end
          checks++; if (rsp_err !== e.err) begin errors++; $display("FAIL wr_dly_err: got %b want %b", rsp_err, e.err); end
          checks++; if (cyc + 1 - e.t != e.lat) begin errors++; $display("FAIL wr_dly_latency: got %0d want %0d", cyc + 1 - e.t, e.lat); end
        end
      end
      wready  = (rel == 1);
      awready = (rel == 4);
    end
    checks++; if (nrsp != 1) begin errors++; $display("FAIL wr_dly_rsp_count: got %0d want 1", nrsp); end
    exp_q.delete();
    idle_slave();
  endtask

  task automatic test_read_delayed();
    bit ok; int rel, nrsp, t0; exp_t e;
    nrsp = 0;
    send(1'b0, AP_CTRL, 32'h0, 32'h0000_0004, 1'b0, 6, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rd_accept: cmd_ready %b want 1", cmd_ready); end
    t0 = cyc;
    for (int k = 0; k < 8; k++) begin
      @(negedge axis_clk);
      rel = cyc - t0 + 1;
      if (rel <= 2) begin
        checks++; if (arvalid !== 1'b1 || araddr !== 12'h000) begin errors++; $display("FAIL rd_ar_t%0d: got %b/%h want 1/000", rel, arvalid, araddr); end
        checks++; if ({awvalid, wvalid} !== 2'b00) begin errors++; $display("FAIL rd_no_write_t%0d: got %b want 00", rel, {awvalid, wvalid}); end
      end
      if (rel >= 3 && rel <= 5) begin
        checks++; if ({arvalid, rready} !== 2'b01) begin errors++; $display("FAIL rd_rready_t%0d: got %b want 01", rel, {arvalid, rready}); end
      end
      if (rel == 6) begin
        checks++; if (rready !== 1'b0) begin errors++; $display("FAIL rd_rready_drop: got %b want 0", rready); end
      end
      if (rsp_valid) begin
        nrsp++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rd_unexpected_rsp: queue empty"); end
        else begin
          e = exp_q.pop_front();
          checks++; if (rsp_rdata !== e.rdata) begin errors++; $display("FAIL rd_rdata: got %h want %h", rsp_rdata, e.rdata); end
          checks++; if (rsp_err !== e.err) begin errors++; $display("FAIL rd_err: got %b want %b", rsp_err, e.err); end
          checks++; if (cyc + 1 - e.t != e.lat) begin errors++; $display("FAIL rd_latency: got %0d want %0d", cyc + 1 - e.t, e.lat); end
        end
      end
      arready = (rel == 2);
      rvalid  = (rel == 5);
      rdata   = (rel == 5) ? 32'h0000_0004 : 32'hDEAD_BEEF;
    end
    checks++; if (nrsp != 1) begin errors++; $display("FAIL rd_rsp_count: got %0d want 1", nrsp); end
    exp_q.delete();
    idle_slave();
  endtask

  task automatic test_back_to_back();
    logic [31:0] taps[11];
    logic [31:0] mem[logic [11:0]];
    int idx, n, seen;
    bit acc_pending, want_ready;
    exp_t e;
    foreach (taps[i]) taps[i] = $urandom;
    awready = 1'b1; wready = 1'b1; arready = 1'b1; rvalid = 1'b1;
    idx = 0; n = 0; seen = 0; acc_pending = 1'b0; want_ready = 1'b0;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = tap_addr(0); cmd_wdata = taps[0];
    while (seen < 12 && n < 300) begin
      @(negedge axis_clk);
      n++;
      if (acc_pending) begin
        acc_pending = 1'b0;
        idx++;
        if (idx < 11) begin
          cmd_we = 1'b1; cmd_addr = tap_addr(idx); cmd_wdata = taps[idx];
        end else if (idx == 11) begin
          cmd_we = 1'b0; cmd_addr = 12'h044; cmd_wdata = 32'h0;
        end else begin
          cmd_valid = 1'b0;
        end
      end
      rdata = mem.exists(araddr) ? mem[araddr] : 32'h0;
      if (awvalid && wvalid) mem[awaddr] = wdata;
      checks++; if (awvalid && arvalid) begin errors++; $display("FAIL b2b_exclusive: awvalid %b arvalid %b", awvalid, arvalid); end
      if (rsp_valid) begin
        seen++;
        want_ready = 1'b1;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_unexpected_rsp: queue empty"); end
        else begin
          e = exp_q.pop_front();
          checks++; if (rsp_rdata !== e.rdata) begin errors++; $display("FAIL b2b_rdata_%0d: got %h want %h", seen, rsp_rdata, e.rdata); end
          checks++; if (rsp_err !== e.err) begin errors++; $display("FAIL b2b_err_%0d: got %b want %b", seen, rsp_err, e.err); end
          checks++; if (cyc + 1 - e.t != e.lat) begin errors++; $display("FAIL b2b_latency_%0d: got %0d want %0d", seen, cyc + 1 - e.t, e.lat); end
        end
      end else if (want_ready) begin
        want_ready = 1'b0;
        if (idx < 12) begin
          checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_accept_spacing: cmd_ready %b want 1", cmd_ready); end
        end
      end
      if (cmd_valid && cmd_ready) begin
        if (idx < 11) exp_q.push_back('{rdata: 32'h0, err: 1'b0, lat: 2, t: cyc + 1});
        else          exp_q.push_back('{rdata: taps[1], err: 1'b0, lat: 3, t: cyc + 1});
        acc_pending = 1'b1;
      end
    end
    cmd_valid = 1'b0;
    checks++; if (seen != 12) begin errors++; $display("FAIL b2b_rsp_count: got %0d want 12", seen); end
    checks++; if (!mem.exists(12'h068) || mem[12'h068] !== taps[10]) begin errors++; $display("FAIL b2b_last_tap: got %h want %h", mem.exists(12'h068) ? mem[12'h068] : 32'h0, taps[10]); end
    exp_q.delete();
    idle_slave();
  endtask

  task automatic test_reset_mid_write();
    bit ok; int nrsp;
    nrsp = 0;
    awready = 1'b0; wready = 1'b0;
    send(1'b1, 12'h050, 32'h1234_5678, 32'h0, 1'b0, 2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_mid_accept: cmd_ready %b want 1", cmd_ready); end
    @(negedge axis_clk);
    checks++; if ({awvalid, wvalid, busy} !== 3'b111) begin errors++; $display("FAIL rst_mid_pre: got %b want 111", {awvalid, wvalid, busy}); end
    axis_rst = 1'b1;
    @(negedge axis_clk);
    axis_rst = 1'b0;
    checks++; if ({awvalid, wvalid, busy} !== 3'b000) begin errors++; $display("FAIL rst_mid_drop: got %b want 000", {awvalid, wvalid, busy}); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_idle: cmd_ready %b want 1", cmd_ready); end
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid) nrsp++;
      @(negedge axis_clk);
    end
    checks++; if (nrsp != 0) begin errors++; $display("FAIL rst_mid_no_rsp: got %0d responses want 0", nrsp); end
    exp_q.delete();
    idle_slave();
  endtask

`ifdef AXIL_CFG_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    bit ok; int rel, nrsp, t0; exp_t e;
    nrsp = 0;
    send(1'b0, AP_CTRL, 32'h0, 32'h0, 1'b1, 17, ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_accept: cmd_ready %b want 1", cmd_ready); end
    t0 = cyc;
    for (int k = 0; k < 22; k++) begin
      @(negedge axis_clk);
      rel = cyc - t0 + 1;
      if (rel == 16) begin
        checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL to_arvalid_held: got %b want 1", arvalid); end
      end
      if (rel == 17) begin
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL to_arvalid_drop: got %b want 0", arvalid); end
      end
      if (rsp_valid) begin
        nrsp++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL to_unexpected_rsp: queue empty"); end
        else begin
          e = exp_q.pop_front();
          checks++; if (rsp_rdata !== e.rdata) begin errors++; $display("FAIL to_rdata: got %h want %h", rsp_rdata, e.rdata); end
          checks++; if (rsp_err !== e.err) begin errors++; $display("FAIL to_err: got %b want %b", rsp_err, e.err); end
          checks++; if (cyc + 1 - e.t != e.lat) begin errors++; $display("FAIL to_latency: got %0d want %0d", cyc + 1 - e.t, e.lat); end
        end
      end
      rdata = 32'hBAD0_BAD0;
    end
    checks++; if (nrsp != 1) begin errors++; $display("FAIL to_rsp_count: got %0d want 1", nrsp); end
    exp_q.delete();
    idle_slave();
  endtask
`else
  task automatic test_slow_slave();
    bit ok; int rel, nrsp, t0; exp_t e;
    nrsp = 0;
    send(1'b0, DATA_LEN, 32'h0, 32'h1234_5678, 1'b0, 22, ok);
    checks++; if (!ok) begin errors++; $display("FAIL slow_accept: cmd_ready %b want 1", cmd_ready); end
    t0 = cyc;
    for (int k = 0; k < 25; k++) begin
      @(negedge axis_clk);
      rel = cyc - t0 + 1;
      if (rel == 18) begin
        checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL slow_arvalid_held: got %b want 1", arvalid); end
      end
      if (rsp_valid) begin
        nrsp++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL slow_unexpected_rsp: queue empty"); end
        else begin
          e = exp_q.pop_front();
          checks++; if (rsp_rdata !== e.rdata) begin errors++; $display("FAIL slow_rdata: got %h want %h", rsp_rdata, e.rdata); end
          checks++; if (rsp_err !== e.err) begin errors++; $display("FAIL slow_err: got %b want %b", rsp_err, e.err); end
          checks++; if (cyc + 1 - e.t != e.lat) begin errors++; $display("FAIL slow_latency: got %0d want %0d", cyc + 1 - e.t, e.lat); end
        end
      end
      arready = (rel == 20);
      rvalid  = (rel == 21);
      rdata   = (rel == 21) ? 32'h1234_5678 : 32'h0;
    end
    checks++; if (nrsp != 1) begin errors++; $display("FAIL slow_rsp_count: got %0d want 1", nrsp); end
    exp_q.delete();
    idle_slave();
  endtask
`endif

  initial begin
    test_reset();
    test_write_fast();
    test_write_aw_delayed();
    test_read_delayed();
    test_back_to_back();
    test_reset_mid_write();
`ifdef AXIL_CFG_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_slow_slave();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/axil_cfg_master.md
Name: axil_cfg_master

Overview:
AXI4-Lite initiator that drives the FIR configuration port: programs tap coefficients and data length, sets ap_start, and polls ap_ctrl.
A simple command/response interface from the host-side sequencer or Caravel-side glue is converted into AW/W or AR/R transactions.
It is the opposite end of the FIR's config-write and config-read slaves.
The link has no B channel: a write completes when both AW and W have handshaken.

Parameters:
pADDR_WIDTH, 12, AXI-Lite address width
pDATA_WIDTH, 32, AXI-Lite data width
pTIMEOUT, 16, handshake watchdog limit in cycles (used only with the optional feature)

Ports:
axis_clk  in  1  clock; all logic on rising edge
axis_rst  in  1  synchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_we  in  1  1 = write, 0 = read
cmd_addr  in  pADDR_WIDTH  target address
cmd_wdata  in  pDATA_WIDTH  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  pDATA_WIDTH  read data, valid with rsp_valid (0 for writes)
rsp_err  out  1  timeout flag, valid with rsp_valid
busy  out  1  transaction in flight
awaddr  out  pADDR_WIDTH  write address
awvalid  out  1  write address valid
awready  in  1  write address ready
wdata  out  pDATA_WIDTH  write data
wvalid  out  1  write data valid
wready  in  1  write data ready
araddr  out  pADDR_WIDTH  read address
arvalid  out  1  read address valid
arready  in  1  read address ready
rdata  in  pDATA_WIDTH  read data
rvalid  in  1  read data valid
rready  out  1  read data ready

Behaviour:
- States: IDLE, WR, RD_A, RD_D, RESP.
- Reset (axis_rst=1 at an edge): state=IDLE; every valid/ready output, rsp_valid, rsp_err and busy = 0; address and data outputs = 0. Reset mid-transaction drops all valids at that same edge. No partial transaction is resumed.
- IDLE:
  - cmd_ready=1 combinationally.
  - On accept, cmd_addr/cmd_wdata are registered. Next state is WR if cmd_we=1, else RD_A.
  - busy=1 from the cycle after accept until RESP exits.
- WR:
  - awvalid and wvalid both assert in the first WR cycle, i.e. 1 cycle after accept.
  - Each valid deasserts at the edge where its own ready is sampled high. AW and W may complete in the same or in different cycles, in either order.
  - awaddr/wdata stay stable while the corresponding valid is high.
  - When both handshakes are recorded (per-channel done flags), go to RESP.
- RD_A: arvalid=1 and araddr stable. On arready: arvalid drops, go to RD_D.
- RD_D:
  - rready=1.
  - On rvalid: capture rdata into rsp_rdata, rready drops, go to RESP.
  - rvalid arriving in the same cycle as arready is ignored; only rvalid seen in RD_D counts.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. cmd_ready=0 in RESP, so the minimum command spacing is accept→accept.
- Minimum latency:
  - Write: accept at T, handshakes at T+1, rsp_valid at T+2.
  - Read: accept at T, arready at T+1, rvalid at T+2, rsp_valid at T+3.
- Never asserts awvalid/wvalid and arvalid together. One outstanding transaction only.
- Valids are never withdrawn before handshake, except by reset or timeout.

Optional Feature:
AXIL_CFG_MASTER_TIMEOUT_EN:
- With the macro defined:
  - A per-transaction counter runs in WR/RD_A/RD_D.
  - If pTIMEOUT cycles elapse without completion, all valids/rready drop and the block goes to RESP with rsp_err=1 and rsp_rdata=0.
  - The counter clears on accept.
- Without it: no counter, and rsp_err is tied to 0. The block waits indefinitely (deadlock is the slave's fault).

Decomposition:
- Package fir_axil_pkg holds:
  - the state enum;
  - FIR register map constants: AP_CTRL=0x000, DATA_LEN=0x010, TAP_BASE=0x040, TAP_STRIDE=4;
  - ap_ctrl bit positions: start=0, done=1, idle=2.
- One natural sub-module: axil_chan_hold, a valid-hold/done-flag cell. It is instantiated for AW, W and AR.

Test Plan:
- Write 0x040←0x0000000A, slave awready/wready high immediately → both valids high 1 cycle, rsp_valid at T+2, rsp_err=0.
- Write 0x010←0x00000258, wready at T+1 but awready delayed to T+4 → wvalid drops after T+1, awvalid held with awaddr stable until T+4, rsp_valid at T+5.
- Read 0x000, arready at T+2, rvalid with rdata=0x00000004 at T+5 → rready high T+3..T+5, rsp_rdata=0x00000004 with rsp_valid at T+6.
- Back-to-back: 11 tap writes 0x040..0x068, then read-back of 0x044, with cmd_valid held → each accepted the cycle after the previous RESP, and the read returns the written value.
- axis_rst=1 while in WR with awready=0 → next cycle awvalid=wvalid=busy=0, state IDLE, cmd_ready=1, no rsp_valid.
- With AXIL_CFG_MASTER_TIMEOUT_EN and pTIMEOUT=16, read with arready never asserted → arvalid drops, and rsp_valid with rsp_err=1 and rsp_rdata=0 occurs 17 cycles after accept.
